// File: rtl/compfifo_readout_ctrl_pkg.sv
// Shared constants and FSM encoding for the comparator-FIFO readout controller.
package compfiber_pkg;
  localparam int CMP_WORD_W = 48;
  localparam int TX_W       = 16;

  localparam logic [11:0] HDR_TAG       = 12'hCF0;
  localparam logic [3:0]  TRL_TAG       = 4'hE;
  localparam logic [3:0]  TRL_ABORT_TAG = 4'hD;

  typedef logic [2:0] state_t;
  localparam state_t S_IDLE = 3'd0;
  localparam state_t S_HDR  = 3'd1;
  localparam state_t S_RD   = 3'd2;
  localparam state_t S_LAT  = 3'd3;
  localparam state_t S_B0   = 3'd4;
  localparam state_t S_B1   = 3'd5;
  localparam state_t S_B2   = 3'd6;
  localparam state_t S_TRL  = 3'd7;
endpackage

// File: rtl/compfifo_readout_ctrl_if.sv
// FIFO read side plus 16-bit transmit stream of the readout controller.
interface compfifo_readout_ctrl_if
  import compfiber_pkg::*;
#(parameter int NFIB = 7);
  logic [NFIB-1:0]            fifo_dav;
  logic [CMP_WORD_W*NFIB-1:0] fifo_dout;
  logic [NFIB-1:0]            fifo_rd_en;
  logic                       tx_valid;
  logic [TX_W-1:0]            tx_data;
  logic                       tx_sof;
  logic                       tx_eof;
  logic                       tx_ready;

  modport master (input fifo_dav, fifo_dout, tx_ready,
                  output fifo_rd_en, tx_valid, tx_data, tx_sof, tx_eof);
  modport slave  (output fifo_dav, fifo_dout, tx_ready,
                  input fifo_rd_en, tx_valid, tx_data, tx_sof, tx_eof);
endinterface

// File: rtl/compfifo_readout_ctrl_rr_arbiter.sv
// Combinational round-robin pick: first set req bit at or above ptr, with wrap.
module rr_arbiter #(
  parameter  int N  = 7,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          vld_o
);
  int j;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
    j     = 0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr_i) + i;
      if (j >= N) j = j - N;
      if (!vld_o && req_i[j]) begin
        vld_o    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = IW'(j);
      end
    end
  end
endmodule

// File: rtl/compfifo_readout_ctrl.sv
// Round-robin readout of per-fiber comparator FIFOs into a framed 16-bit stream.
// Optional mid-event FIFO starvation timeout: COMPFIFO_RD_TIMEOUT_EN.
module compfifo_readout_ctrl
  import compfiber_pkg::*;
#(
  parameter int NFIB          = 7,
  parameter int WORDS_PER_EVT = 9,
  parameter int TIMEOUT_CYC   = 256
) (
  input  logic                   fabric_clk,
  input  logic                   reset,
  input  logic [NFIB-1:0]        fiber_en,
  compfifo_readout_ctrl_if.master bus,
  output logic                   busy,
  output logic [15:0]            evt_count,
  output logic                   underrun
);
  localparam int IW = (NFIB > 1) ? $clog2(NFIB) : 1;
  localparam int WW = (WORDS_PER_EVT > 1) ? $clog2(WORDS_PER_EVT) : 1;

  state_t                  state_q, state_d;
  logic [IW-1:0]           gidx_q, gidx_d, ptr_q, ptr_d, arb_idx;
  logic [WW-1:0]           wcnt_q, wcnt_d;
  logic [CMP_WORD_W-1:0]   sr_q, sr_d;
  logic [15:0]             evt_q, evt_d;
  logic [NFIB-1:0]         req, unused_gnt;
  logic                    arb_vld, accept, dav_g, to_hit, trl_abort;
  logic [3:0]              gnt_nib;

  assign req = bus.fifo_dav & fiber_en;

  rr_arbiter #(.N(NFIB)) u_arb (
    .req_i (req),
    .ptr_i (ptr_q),
    .gnt_o (unused_gnt),
    .idx_o (arb_idx),
    .vld_o (arb_vld)
  );

  assign dav_g   = bus.fifo_dav[gidx_q];
  assign gnt_nib = 4'(gidx_q);

  assign bus.tx_valid   = (state_q == S_HDR) || (state_q == S_B0) || (state_q == S_B1) ||
                          (state_q == S_B2)  || (state_q == S_TRL);
  assign bus.tx_sof     = (state_q == S_HDR);
  assign bus.tx_eof     = (state_q == S_TRL);
  assign accept         = bus.tx_valid && bus.tx_ready;
  assign bus.fifo_rd_en = (state_q == S_RD && dav_g) ? (NFIB'(1) << gidx_q) : '0;
  assign busy           = (state_q != S_IDLE);
  assign evt_count      = evt_q;

  // Beats always come from the top of the shift register, so data holds under stall.
  always_comb begin
    bus.tx_data = '0;
    case (state_q)
      S_HDR:             bus.tx_data = {HDR_TAG, gnt_nib};
      S_B0, S_B1, S_B2:  bus.tx_data = sr_q[CMP_WORD_W-1 -: TX_W];
      S_TRL:             bus.tx_data = {trl_abort ? TRL_ABORT_TAG : TRL_TAG, evt_q[11:0]};
      default:           bus.tx_data = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    gidx_d  = gidx_q;
    ptr_d   = ptr_q;
    wcnt_d  = wcnt_q;
    sr_d    = sr_q;
    evt_d   = evt_q;
    case (state_q)
      S_IDLE: if (arb_vld) begin
        gidx_d  = arb_idx;
        state_d = S_HDR;
      end
      S_HDR: if (accept) begin
        wcnt_d  = '0;
        state_d = S_RD;
      end
      S_RD: begin
        if (dav_g)       state_d = S_LAT;
        else if (to_hit) state_d = S_TRL;
      end
      S_LAT: begin
        sr_d    = bus.fifo_dout[gidx_q*CMP_WORD_W +: CMP_WORD_W];
        state_d = S_B0;
      end
      S_B0: if (accept) begin
        sr_d    = sr_q << TX_W;
        state_d = S_B1;
      end
      S_B1: if (accept) begin
        sr_d    = sr_q << TX_W;
        state_d = S_B2;
      end
      S_B2: if (accept) begin
        if (wcnt_q == WW'(WORDS_PER_EVT-1)) state_d = S_TRL;
        else begin
          wcnt_d  = wcnt_q + 1'b1;
          state_d = S_RD;
        end
      end
      S_TRL: if (accept) begin
        evt_d   = evt_q + 16'd1;
        ptr_d   = (gidx_q == IW'(NFIB-1)) ? '0 : gidx_q + 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge fabric_clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      gidx_q  <= '0;
      ptr_q   <= '0;
      wcnt_q  <= '0;
      sr_q    <= '0;
      evt_q   <= '0;
    end else begin
      state_q <= state_d;
      gidx_q  <= gidx_d;
      ptr_q   <= ptr_d;
      wcnt_q  <= wcnt_d;
      sr_q    <= sr_d;
      evt_q   <= evt_d;
    end
  end

`ifdef COMPFIFO_RD_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          abort_q, abort_d, underrun_q, underrun_d;

  // The wait counter only runs while stalled in RD on an empty granted FIFO.
  assign to_hit     = (state_q == S_RD) && !dav_g && (tcnt_q == TW'(TIMEOUT_CYC-1));
  assign tcnt_d     = ((state_q == S_RD) && !dav_g && !to_hit) ? tcnt_q + 1'b1 : '0;
  assign abort_d    = to_hit ? 1'b1 : ((state_q == S_IDLE) ? 1'b0 : abort_q);
  assign underrun_d = underrun_q | to_hit;
  assign trl_abort  = abort_q;
  assign underrun   = underrun_q;

  always_ff @(posedge fabric_clk or posedge reset) begin
    if (reset) begin
      tcnt_q     <= '0;
      abort_q    <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      tcnt_q     <= tcnt_d;
      abort_q    <= abort_d;
      underrun_q <= underrun_d;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^TIMEOUT_CYC;
  assign to_hit     = 1'b0;
  assign trl_abort  = 1'b0;
  assign underrun   = 1'b0;
`endif
endmodule

// File: tb/tb_compfifo_readout_ctrl.sv
// Scoreboard bench for compfifo_readout_ctrl with a behavioural non-FWFT FIFO per fiber.
module tb_compfifo_readout_ctrl;
  import compfiber_pkg::*;

  localparam int NFIB = 7;
  localparam logic [47:0] NOM_BASE = 48'h0000_1111_2222;

  logic            fabric_clk = 1'b0;
  logic            reset = 1'b1;
  logic [NFIB-1:0] fiber_en;
  logic            busy, underrun;
  logic [15:0]     evt_count;

  compfifo_readout_ctrl_if #(.NFIB(NFIB)) bus ();

  compfifo_readout_ctrl #(.NFIB(NFIB), .WORDS_PER_EVT(9), .TIMEOUT_CYC(256)) dut (
    .fabric_clk (fabric_clk),
    .reset      (reset),
    .fiber_en   (fiber_en),
    .bus        (bus.master),
    .busy       (busy),
    .evt_count  (evt_count),
    .underrun   (underrun)
  );

  always #5 fabric_clk = ~fabric_clk;

  int checks = 0;
  int passes = 0;
  int acc_cnt = 0, rd_cnt = 0, busy_cyc = 0, stab_err = 0;
  logic [17:0] exp_q[$];
  logic [47:0] fq[NFIB][$];
  logic        stall_q = 1'b0;
  logic [17:0] hold_beat = '0;

  // Non-FWFT FIFO model: data appears the cycle after the read strobe.
  always @(posedge fabric_clk) begin
    for (int i = 0; i < NFIB; i++) begin
      if (bus.fifo_rd_en[i] && fq[i].size() > 0)
        bus.fifo_dout[i*48 +: 48] <= fq[i].pop_front();
      bus.fifo_dav[i] <= (fq[i].size() > 0);
    end
  end

  // Stream monitor: pops the scoreboard on every accepted beat.
  always @(negedge fabric_clk) begin
    logic [17:0] beat, e;
    if (!reset) begin
      beat = {bus.tx_data, bus.tx_sof, bus.tx_eof};
      if (stall_q && (!bus.tx_valid || beat !== hold_beat)) stab_err++;
      stall_q   = bus.tx_valid && !bus.tx_ready;
      hold_beat = beat;
      if (bus.fifo_rd_en != '0) rd_cnt++;
      if (busy) busy_cyc++;
      if (bus.tx_valid && bus.tx_ready) begin
        acc_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL beat: unexpected beat got %h (data,sof,eof) with empty scoreboard", beat);
        end else begin
          e = exp_q.pop_front();
          if (beat !== e) $display("FAIL beat %0d: got %h want %h", acc_cnt, beat, e);
          else passes++;
        end
      end
    end
  end

  task automatic load_fifo(input int f, input logic [47:0] base, input int k0, input int n);
    for (int k = k0; k < k0 + n; k++) fq[f].push_back(base + 48'(k));
  endtask

  task automatic push_evt(input int f, input logic [47:0] base, input int nw,
                          input logic [3:0] tag, input int evt);
    logic [47:0] w;
    exp_q.push_back({HDR_TAG, 4'(f), 2'b10});
    for (int k = 0; k < nw; k++) begin
      w = base + 48'(k);
      exp_q.push_back({w[47:32], 2'b00});
      exp_q.push_back({w[31:16], 2'b00});
      exp_q.push_back({w[15:0],  2'b00});
    end
    exp_q.push_back({tag, 12'(evt), 2'b01});
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    fiber_en = '1;
    bus.tx_ready = 1'b1;
    for (int i = 0; i < NFIB; i++) fq[i].delete();
    exp_q.delete();
    repeat (3) @(posedge fabric_clk);
    #1 reset = 1'b0;
    acc_cnt = 0; rd_cnt = 0; busy_cyc = 0; stab_err = 0; stall_q = 1'b0;
  endtask

  task automatic drain(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge fabric_clk);
      if (exp_q.size() == 0 && !busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [40:0] obs;
    fiber_en = '1;
    bus.tx_ready = 1'b1;
    @(negedge fabric_clk);
    obs = {bus.tx_valid, bus.tx_sof, bus.tx_eof, bus.fifo_rd_en, busy, evt_count, underrun, bus.tx_data};
    checks++;
    if (obs !== '0) $display("FAIL reset_hold: outputs got %h want 0", obs);
    else passes++;
    @(posedge fabric_clk);
    #1 reset = 1'b0;
    @(negedge fabric_clk);
    obs = {bus.tx_valid, bus.tx_sof, bus.tx_eof, bus.fifo_rd_en, busy, evt_count, underrun, bus.tx_data};
    checks++;
    if (obs !== '0) $display("FAIL reset_release: outputs got %h want 0", obs);
    else passes++;
  endtask

  task automatic test_nominal();
    bit ok;
    apply_reset();
    load_fifo(2, NOM_BASE, 0, 9);
    push_evt(2, NOM_BASE, 9, TRL_TAG, 0);
    drain(500, ok);
    checks++; if (!ok) $display("FAIL nominal_done: event not drained, %0d beats left", exp_q.size()); else passes++;
    checks++; if (acc_cnt !== 29) $display("FAIL nominal_beats: got %0d want 29", acc_cnt); else passes++;
    checks++; if (rd_cnt !== 9) $display("FAIL nominal_rd: got %0d want 9", rd_cnt); else passes++;
    checks++; if (busy_cyc !== 47) $display("FAIL nominal_cycles: got %0d want 47", busy_cyc); else passes++;
    checks++; if (evt_count !== 16'd1) $display("FAIL nominal_evt: got %0d want 1", evt_count); else passes++;
  endtask

  task automatic test_round_robin();
    bit ok;
    apply_reset();
    load_fifo(0, 48'h0A00_0000_0000, 0, 18);
    load_fifo(3, 48'h0B00_0000_0000, 0, 18);
    push_evt(0, 48'h0A00_0000_0000, 9, TRL_TAG, 0);
    push_evt(3, 48'h0B00_0000_0000, 9, TRL_TAG, 1);
    push_evt(0, 48'h0A00_0000_0009, 9, TRL_TAG, 2);
    push_evt(3, 48'h0B00_0000_0009, 9, TRL_TAG, 3);
    drain(1000, ok);
    checks++; if (!ok) $display("FAIL rr_done: %0d beats left", exp_q.size()); else passes++;
    checks++; if (evt_count !== 16'd4) $display("FAIL rr_evt: got %0d want 4", evt_count); else passes++;
    checks++; if (rd_cnt !== 36) $display("FAIL rr_rd: got %0d want 36", rd_cnt); else passes++;
  endtask

  task automatic test_backpressure();
    bit done;
    apply_reset();
    load_fifo(2, NOM_BASE, 0, 9);
    push_evt(2, NOM_BASE, 9, TRL_TAG, 0);
    done = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(posedge fabric_clk);
      #1 bus.tx_ready = ($urandom_range(0, 9) < 3);
      if (exp_q.size() == 0 && !busy) begin
        done = 1'b1;
        break;
      end
    end
    bus.tx_ready = 1'b1;
    checks++; if (!done) $display("FAIL bp_done: %0d beats left", exp_q.size()); else passes++;
    checks++; if (stab_err !== 0) $display("FAIL bp_stable: got %0d changes under stall want 0", stab_err); else passes++;
    checks++; if (acc_cnt !== 29) $display("FAIL bp_beats: got %0d want 29", acc_cnt); else passes++;
    checks++; if (evt_count !== 16'd1) $display("FAIL bp_evt: got %0d want 1", evt_count); else passes++;
  endtask

  task automatic test_mask();
    bit ok;
    int viol;
    apply_reset();
    fiber_en = 7'b1111101;
    load_fifo(1, 48'h0C00_0000_0100, 0, 9);
    viol = 0;
    repeat (20) begin
      @(negedge fabric_clk);
      if (busy || bus.fifo_rd_en[1]) viol++;
    end
    checks++; if (viol !== 0) $display("FAIL mask_hold: got %0d active cycles want 0", viol); else passes++;
    push_evt(1, 48'h0C00_0000_0100, 9, TRL_TAG, 0);
    @(posedge fabric_clk);
    #1 fiber_en = '1;
    @(posedge fabric_clk);
    #1;
    checks++;
    if ({bus.tx_valid, bus.tx_sof, bus.tx_data} !== {2'b11, 16'hCF01})
      $display("FAIL mask_hdr: got valid=%b sof=%b data=%h want 1 1 cf01", bus.tx_valid, bus.tx_sof, bus.tx_data);
    else passes++;
    drain(500, ok);
    checks++; if (!ok || evt_count !== 16'd1) $display("FAIL mask_done: ok=%0d evt=%0d want 1 1", ok, evt_count); else passes++;
  endtask

  task automatic test_timeout();
    bit ok;
    apply_reset();
    load_fifo(4, 48'h0D00_0000_0040, 0, 4);
`ifdef COMPFIFO_RD_TIMEOUT_EN
    push_evt(4, 48'h0D00_0000_0040, 4, TRL_ABORT_TAG, 0);
    drain(1000, ok);
    checks++; if (!ok) $display("FAIL to_done: %0d beats left", exp_q.size()); else passes++;
    checks++; if (underrun !== 1'b1) $display("FAIL to_underrun: got %b want 1", underrun); else passes++;
    checks++; if (evt_count !== 16'd1) $display("FAIL to_evt: got %0d want 1", evt_count); else passes++;
    checks++; if (rd_cnt !== 4) $display("FAIL to_rd: got %0d want 4", rd_cnt); else passes++;
`else
    push_evt(4, 48'h0D00_0000_0040, 9, TRL_TAG, 0);
    repeat (400) @(negedge fabric_clk);
    checks++;
    if ({busy, underrun} !== 2'b10 || acc_cnt !== 13)
      $display("FAIL to_wait: got busy=%b underrun=%b beats=%0d want 1 0 13", busy, underrun, acc_cnt);
    else passes++;
    load_fifo(4, 48'h0D00_0000_0040, 4, 5);
    drain(500, ok);
    checks++; if (!ok) $display("FAIL to_refill: %0d beats left", exp_q.size()); else passes++;
    checks++; if (evt_count !== 16'd1) $display("FAIL to_evt: got %0d want 1", evt_count); else passes++;
    checks++; if (rd_cnt !== 9) $display("FAIL to_rd: got %0d want 9", rd_cnt); else passes++;
`endif
  endtask

  task automatic test_reset_mid();
    bit ok;
    apply_reset();
    load_fifo(3, 48'h0E00_0000_0000, 0, 18);
    push_evt(3, 48'h0E00_0000_0000, 9, TRL_TAG, 0);
    push_evt(3, 48'h0E00_0000_0009, 9, TRL_TAG, 1);
    // 46 = full first event (29) + header, five words and B0 of the second event.
    for (int c = 0; c < 2000; c++) begin
      @(posedge fabric_clk);
      if (acc_cnt >= 46) break;
    end
    checks++;
    if (acc_cnt !== 46 || evt_count !== 16'd1)
      $display("FAIL rst_pre: got beats=%0d evt=%0d want 46 1", acc_cnt, evt_count);
    else passes++;
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({bus.tx_valid, bus.fifo_rd_en, evt_count, busy} !== '0)
      $display("FAIL rst_drop: got valid=%b rd=%b evt=%0d busy=%b want all 0",
               bus.tx_valid, bus.fifo_rd_en, evt_count, busy);
    else passes++;
    for (int i = 0; i < NFIB; i++) fq[i].delete();
    exp_q.delete();
    repeat (2) @(posedge fabric_clk);
    #1 reset = 1'b0;
    acc_cnt = 0; rd_cnt = 0; busy_cyc = 0; stab_err = 0; stall_q = 1'b0;
    load_fifo(5, 48'h0F00_0000_0500, 0, 9);
    load_fifo(0, 48'h0F00_0000_0000, 0, 9);
    push_evt(0, 48'h0F00_0000_0000, 9, TRL_TAG, 0);
    push_evt(5, 48'h0F00_0000_0500, 9, TRL_TAG, 1);
    drain(1000, ok);
    checks++;
    if (!ok || evt_count !== 16'd2)
      $display("FAIL rst_after: ok=%0d evt=%0d want 1 2", ok, evt_count);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_round_robin();
    test_backpressure();
    test_mask();
    test_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/compfifo_readout_ctrl.md
# compfifo_readout_ctrl

Round-robin readout controller for the per-fiber comparator FIFOs. It runs in the fabric clock domain, downstream of the comparator-fiber receivers. When a receiver's FIFO holds a saved event (three triads, 9 × 48-bit words), the block grants that fiber and drains exactly one event with single-cycle read strobes. It serialises each 48-bit word into three 16-bit beats on a valid/ready stream toward the GbE transmit packer, framing every event with a header beat and a trailer beat.

## Interface
Parameters:
- NFIB, 7: number of comparator fibers/FIFOs.
- WORDS_PER_EVT, 9: 48-bit words drained per event.
- TIMEOUT_CYC, 256: cycles allowed waiting on FIFO data mid-event (used only with the macro).

Ports:
- fabric_clk  in  1  single clock for all logic.
- reset  in  1  asynchronous, active-high; clears all state.
- fiber_en  in  NFIB  per-fiber enable mask.
- fifo_dav  in  NFIB  FIFO not-empty, already in the fabric domain.
- fifo_dout  in  48*NFIB  FIFO read data; fiber i occupies bits [48i+47:48i]. Non-FWFT: valid the cycle after rd_en.
- fifo_rd_en  out  NFIB  one-cycle read strobe, one-hot or zero.
- tx_valid  out  1  stream beat valid.
- tx_data  out  16  stream beat.
- tx_sof / tx_eof  out  1  mark the header beat and the trailer beat.
- tx_ready  in  1  downstream accept.
- busy  out  1  high in any state other than IDLE.
- evt_count  out  16  completed events; wraps at 16'hFFFF→0.
- underrun  out  1  sticky timeout flag.

## Operation
States: IDLE, HDR, RD, LAT, B0, B1, B2, TRL.

- **IDLE**
  - req = fifo_dav & fiber_en.
  - If any req bit is set, grant the first set bit found by searching upward from ptr with wrap, register it as gnt, then go to HDR.
  - Otherwise stay in IDLE.
- **HDR**
  - tx_data = {12'hCF0, gnt[3:0]}, tx_sof = 1.
  - On accept, clear wcnt and go to RD.
- **RD**
  - When fifo_dav[gnt] = 1, pulse fifo_rd_en[gnt] for one cycle and go to LAT.
  - Otherwise wait in RD.
- **LAT**
  - Capture fifo_dout[gnt] into the 48-bit shift register and go to B0.
- **B0 / B1 / B2**
  - Beats are sent MSB first: bits [47:32], then [31:16], then [15:0].
  - Each beat advances only on accept.
  - After B2 is accepted: if wcnt == WORDS_PER_EVT-1, go to TRL; otherwise increment wcnt and go to RD.
- **TRL**
  - tx_data = {4'hE, evt_count[11:0]}, tx_eof = 1.
  - On accept: increment evt_count, set ptr = gnt+1 (wrapping NFIB-1→0), go to IDLE.

General rules:
- Accept = tx_valid & tx_ready.
- tx_valid is high only in HDR, B0–B2 and TRL.
- tx_data, tx_sof and tx_eof are held stable while tx_valid=1 and tx_ready=0.
- fiber_en and fifo_dav of other fibers are ignored after a grant. A mask change takes effect at the next IDLE arbitration.
- A normal event is 29 beats: 1 header + 27 data + 1 trailer.
- fifo_rd_en is never asserted outside RD, so there is at most one read per word and never a read while the FIFO is empty.

## Timing
- Values after reset: all outputs 0, state IDLE, ptr 0, wcnt 0, evt_count 0, underrun 0.
- A req seen in IDLE at cycle n gives a header on tx_valid at cycle n+1.
- With tx_ready held high, one word takes 5 cycles (RD, LAT, B0, B1, B2). An event takes 1 + 9×5 + 1 = 47 cycles, plus 1 IDLE cycle between events.
- Reset is asynchronous. If asserted mid-event:
  - outputs drop immediately;
  - the partial event is abandoned with no trailer;
  - the FIFOs are reset externally by the same reset.

## Configuration
- COMPFIFO_RD_TIMEOUT_EN defined:
  - a counter runs in RD while fifo_dav[gnt] = 0;
  - when it reaches TIMEOUT_CYC, skip the remaining words and go to TRL;
  - the trailer is {4'hD, evt_count[11:0]}, underrun is set (sticky until reset), and evt_count still increments.
- COMPFIFO_RD_TIMEOUT_EN undefined: RD waits indefinitely, and underrun is tied to 0.

## Structure
- Package compfiber_pkg holds:
  - the state enum;
  - HDR_TAG 12'hCF0, TRL_TAG 4'hE, TRL_ABORT_TAG 4'hD;
  - CMP_WORD_W = 48, TX_W = 16.
- Sub-module rr_arbiter (parameter N): a combinational round-robin priority pick from req and ptr, giving a one-hot grant plus its index and a valid flag.

## Test plan
- **Single fiber, nominal:** fiber 2 FIFO preloaded with 9 words {word k = 48'h0000_1111_2222 + k}, tx_ready = 1.
  - 29 beats: first 16'hCF02 with sof.
  - Data beats: 0000, 1111, 2222, 0000, 1111, 2223, ….
  - Last beat 16'hE000 with eof; evt_count = 1; exactly 9 rd_en pulses.
- **Round robin:** fibers 0 and 3 each hold 2 events.
  - Grant order is 0, 3, 0, 3; evt_count = 4.
- **Backpressure:** random tx_ready at 30% duty.
  - Beat sequence identical to the nominal case.
  - tx_data never changes while valid & !ready.
- **Mask:** fiber 1 dav = 1 with fiber_en[1] = 0.
  - fifo_rd_en[1] never asserts and busy stays 0.
  - Setting fiber_en[1] = 1 produces header 16'hCF01 on the next cycle.
- **Timeout:** fiber 4 supplies 4 words, then dav = 0.
  - Macro on: after 256 idle cycles the trailer is 16'hD000 and underrun = 1.
  - Macro off: the block stays in RD; refilling the FIFO completes the event with trailer 16'hE000.
- **Reset mid-event:** assert reset during B1 of word 5.
  - tx_valid, fifo_rd_en and evt_count go to 0 the same cycle.
  - After release, the next event starts with the header from fiber 0 priority.
